// File: rtl/vexec_seq.sv
// Vector execution sequencer: accepts one vector instruction at a time and
// steps through the N-register group, reading sources, feeding the ALU and
// issuing one registered write per group member (tail elements undisturbed).
module vexec_seq #(
  parameter int VLEN = 128
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [2:0]               i_sew,
  input  logic [5:0]               i_ctrl,
  input  logic [1:0]               i_lmul,
  input  logic [4:0]               i_vs1,
  input  logic [4:0]               i_vs2,
  input  logic [4:0]               i_vd,
  input  logic [$clog2(VLEN):0]    i_vl,
  output logic [4:0]               o_rf_ra1,
  output logic [4:0]               o_rf_ra2,
  output logic [4:0]               o_rf_ra3,
  input  logic [VLEN-1:0]          i_rf_rd1,
  input  logic [VLEN-1:0]          i_rf_rd2,
  input  logic [VLEN-1:0]          i_rf_rd3,
  output logic [2:0]               o_alu_sew,
  output logic [5:0]               o_alu_ctrl,
  output logic [VLEN-1:0]          o_alu_a,
  output logic [VLEN-1:0]          o_alu_b,
  input  logic [VLEN-1:0]          i_alu_result,
  output logic                     o_rf_we,
  output logic [4:0]               o_rf_wa,
  output logic [VLEN-1:0]          o_rf_wd,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_illegal
);

  localparam int VLW = $clog2(VLEN) + 1;
  localparam int EB  = VLEN / 8;
  localparam int KSH = $clog2(VLEN / 8);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t           r_state;
  logic [2:0]       r_k;
  logic [2:0]       r_sew;
  logic [5:0]       r_ctrl;
  logic [1:0]       r_lmul;
  logic [4:0]       r_vs1;
  logic [4:0]       r_vs2;
  logic [4:0]       r_vd;
  logic [VLW-1:0]   r_vl;
  logic             r_we;
  logic [4:0]       r_wa;
  logic [VLEN-1:0]  r_wd;
  logic             r_done;
  logic             r_ill;
  logic             r_busy;
  logic             r_ready;

  logic [VLW-1:0]   w_vlmax;
  logic [VLW-1:0]   w_vl_eff;
  logic [2:0]       w_kmax;
  logic [VLW-1:0]   w_kbase;
  logic             w_run;
  logic [EB-1:0]    w_bsel;
  logic [VLEN-1:0]  w_wd;

  // VLMAX = N * VLEN / (8<<sew), evaluated on the incoming instruction
  assign w_vlmax  = VLW'((VLEN / 8) >> i_sew) << i_lmul;
  assign w_vl_eff = (i_vl > w_vlmax) ? w_vlmax : i_vl;
  // N-1; for N=8 the 3-bit shift wraps to 0 and the subtract yields 7
  assign w_kmax   = (3'd1 << r_lmul) - 3'd1;
  // first global byte index of member k
  assign w_kbase  = VLW'(r_k) << KSH;
  assign w_run    = (r_state == RUN);

  // Byte-granular tail mask: element index of byte b is (kbase+b)>>sew
  for (genvar b = 0; b < EB; b++) begin : g_byte
    assign w_bsel[b]       = ((w_kbase + VLW'(b)) >> r_sew) < r_vl;
    assign w_wd[8*b +: 8]  = w_bsel[b] ? i_alu_result[8*b +: 8] : i_rf_rd3[8*b +: 8];
  end

  assign o_rf_ra1   = w_run ? r_vs1 + {2'b00, r_k} : '0;
  assign o_rf_ra2   = w_run ? r_vs2 + {2'b00, r_k} : '0;
  assign o_rf_ra3   = w_run ? r_vd  + {2'b00, r_k} : '0;
  assign o_alu_a    = w_run ? i_rf_rd2 : '0;
  assign o_alu_b    = w_run ? i_rf_rd1 : '0;
  assign o_alu_sew  = r_sew;
  assign o_alu_ctrl = r_ctrl;
  assign o_rf_we    = r_we;
  assign o_rf_wa    = r_wa;
  assign o_rf_wd    = r_wd;
  assign o_busy     = r_busy;
  assign o_done     = r_done;
  assign o_illegal  = r_ill;
  assign o_ready    = r_ready;

  // Sequencer FSM with registered write stage and status outputs
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_sew   <= '0;
      r_ctrl  <= '0;
      r_lmul  <= '0;
      r_vs1   <= '0;
      r_vs2   <= '0;
      r_vd    <= '0;
      r_vl    <= '0;
      r_we    <= 1'b0;
      r_wa    <= '0;
      r_wd    <= '0;
      r_done  <= 1'b0;
      r_ill   <= 1'b0;
      r_busy  <= 1'b0;
      r_ready <= 1'b1;
    end else begin
      case (r_state)
        IDLE: begin
          r_we <= 1'b0;
          if (i_valid) begin
            r_sew   <= i_sew;
            r_ctrl  <= i_ctrl;
            r_lmul  <= i_lmul;
            r_vs1   <= i_vs1;
            r_vs2   <= i_vs2;
            r_vd    <= i_vd;
            r_vl    <= w_vl_eff;
            r_k     <= '0;
            r_ready <= 1'b0;
            r_busy  <= 1'b1;
            if (i_sew > 3'd3) begin
              r_state <= DRAIN;
              r_done  <= 1'b1;
              r_ill   <= 1'b1;
            end else if (i_vl == '0) begin
              r_state <= DRAIN;
              r_done  <= 1'b1;
            end else begin
              r_state <= RUN;
            end
          end
        end
        RUN: begin
          r_we <= 1'b1;
          r_wa <= r_vd + {2'b00, r_k};
          r_wd <= w_wd;
          r_k  <= r_k + 3'd1;
          if (r_k == w_kmax) begin
            r_state <= DRAIN;
            r_done  <= 1'b1;
          end
        end
        DRAIN: begin
          r_state <= IDLE;
          r_we    <= 1'b0;
          r_k     <= '0;
          r_done  <= 1'b0;
          r_ill   <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
        default: begin
          r_state <= IDLE;
          r_we    <= 1'b0;
          r_done  <= 1'b0;
          r_ill   <= 1'b0;
          r_busy  <= 1'b0;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
